// File: rtl/ca_ingr_rcv_pkg.sv
// ca_ingr_rcv_pkg: shared constants and types for the ingress receive protocol error path
package ca_ingr_rcv_pkg;
    localparam int ERR_W = 16;
    localparam int RESP_CHANNEL      = 0;
    localparam int RESP_ID           = 1;
    localparam int RESP_LAST         = 2;
    localparam int RESP_ORDER        = 3;
    localparam int RESP_STRB         = 4;
    localparam int RESP_ADDR_ALIGN   = 5;
    localparam int RESP_BOUNDARY     = 6;
    localparam int RESP_SIZE         = 7;
    localparam int RESP_BURST_TYPE   = 8;
    localparam int RESP_OVERFLOW     = 9;
    localparam int RESP_UNDERFLOW    = 12;
    localparam int RESP_BURST_LEN_EQ = 13;
    localparam logic [ERR_W-1:0] RSVD_MASK = 16'hCC00;
    typedef enum logic {CAP_IDLE, CAP_CAPTURED} cap_state_e;
endpackage

// File: rtl/ca_sat_counter.sv
// ca_sat_counter: saturating up-counter; clear with a simultaneous increment loads 1
module ca_sat_counter #(
    parameter int W = 32
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n)
            q <= '0;
        else if (clr)
            q <= W'(inc);
        else if (inc && q != '1)
            q <= q + W'(1);
endmodule

// File: rtl/ca_ingr_rcv_protocol_error_collector.sv
// ca_ingr_rcv_protocol_error_collector: sticky/W1C status, saturating event count, first-error capture, irq
module ca_ingr_rcv_protocol_error_collector #(
    parameter int ERR_W = ca_ingr_rcv_pkg::ERR_W,
    parameter int CNT_W = 32,
    parameter int TS_W  = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [ERR_W-1:0] protocol_error,
    input  logic             protocol_error_ap_vld,
    input  logic [ERR_W-1:0] err_mask,
    input  logic             irq_en,
    input  logic [ERR_W-1:0] clr_sticky,
    input  logic             clr_count,
    input  logic             clr_first,
    output logic [ERR_W-1:0] err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [ERR_W-1:0] err_first,
    output logic [TS_W-1:0]  err_first_ts,
    output logic             err_first_vld,
    output logic             irq
);
    import ca_ingr_rcv_pkg::*;

    logic [ERR_W-1:0] ev_vec, sticky_nxt, first_nxt;
    logic [TS_W-1:0]  ts, first_ts_nxt;
    logic             ev;
    cap_state_e       state, state_nxt;

    assign ev_vec        = protocol_error_ap_vld ? protocol_error & ~err_mask : '0;
    assign ev            = |ev_vec;
    assign sticky_nxt    = (err_sticky & ~clr_sticky) | ev_vec;
    assign err_first_vld = state == CAP_CAPTURED;

    // an event arriving with clr_first recaptures rather than releasing
    always_comb begin
        state_nxt    = state;
        first_nxt    = err_first;
        first_ts_nxt = err_first_ts;
        if (ev && (state == CAP_IDLE || clr_first)) begin
            state_nxt    = CAP_CAPTURED;
            first_nxt    = ev_vec;
            first_ts_nxt = ts;
        end else if (clr_first && state == CAP_CAPTURED) begin
            state_nxt    = CAP_IDLE;
            first_nxt    = '0;
            first_ts_nxt = '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            ts           <= '0;
            err_sticky   <= '0;
            irq          <= 1'b0;
            state        <= CAP_IDLE;
            err_first    <= '0;
            err_first_ts <= '0;
        end else begin
            ts           <= ts + TS_W'(1);
            err_sticky   <= sticky_nxt;
            irq          <= irq_en & |(sticky_nxt & ~err_mask);
            state        <= state_nxt;
            err_first    <= first_nxt;
            err_first_ts <= first_ts_nxt;
        end

    ca_sat_counter #(.W(CNT_W)) u_cnt (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .inc     (ev),
        .clr     (clr_count),
        .q       (err_count)
    );
endmodule

// File: tb/tb_ca_ingr_rcv_protocol_error_collector.sv
// tb_ca_ingr_rcv_protocol_error_collector: directed vectors, expected responses queued and checked by a monitor
module tb_ca_ingr_rcv_protocol_error_collector;
    logic        ap_clk = 1'b0, ap_rst_n = 1'b0;
    logic [15:0] protocol_error = '0, err_mask = '0, clr_sticky = '0;
    logic        vld = 1'b0, irq_en = 1'b0, clr_count = 1'b0, clr_first = 1'b0;
    logic [15:0] l_sticky, l_first, s_sticky, s_first;
    logic [31:0] l_count, l_ts;
    logic [3:0]  s_count, s_ts;
    logic        l_fv, l_irq, s_fv, s_irq;

    ca_ingr_rcv_protocol_error_collector dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .protocol_error(protocol_error),
        .protocol_error_ap_vld(vld), .err_mask(err_mask), .irq_en(irq_en),
        .clr_sticky(clr_sticky), .clr_count(clr_count), .clr_first(clr_first),
        .err_sticky(l_sticky), .err_count(l_count), .err_first(l_first),
        .err_first_ts(l_ts), .err_first_vld(l_fv), .irq(l_irq)
    );

    ca_ingr_rcv_protocol_error_collector #(.CNT_W(4), .TS_W(4)) dut_s (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .protocol_error(protocol_error),
        .protocol_error_ap_vld(vld), .err_mask(err_mask), .irq_en(irq_en),
        .clr_sticky(clr_sticky), .clr_count(clr_count), .clr_first(clr_first),
        .err_sticky(s_sticky), .err_count(s_count), .err_first(s_first),
        .err_first_ts(s_ts), .err_first_vld(s_fv), .irq(s_irq)
    );

    always #5 ap_clk = ~ap_clk;

    int          cyc = 0;
    logic [31:0] ts_m;
    int          errors = 0, checks = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;
    always @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) ts_m <= '0;
        else ts_m <= ts_m + 1;

    typedef struct {
        int          due;
        bit          sel;
        string       tag;
        logic [15:0] sticky;
        logic [31:0] count;
        logic [15:0] first;
        logic [31:0] ts;
        logic        fv;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_nxt(bit sel, string tag, logic [15:0] st, logic [31:0] cnt,
                              logic [15:0] fi, logic [31:0] ft, logic fv, logic iq);
        exp_t e;
        e.due = cyc + 1; e.sel = sel; e.tag = tag;
        e.sticky = st; e.count = cnt; e.first = fi; e.ts = ft; e.fv = fv; e.irq = iq;
        exp_q.push_back(e);
    endtask

    exp_t m;
    always @(negedge ap_clk)
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            m = exp_q.pop_front();
            if (m.sel) begin
                chk({m.tag, ".sticky"}, {16'h0, s_sticky}, {16'h0, m.sticky});
                chk({m.tag, ".count"},  {28'h0, s_count},  m.count);
                chk({m.tag, ".first"},  {16'h0, s_first},  {16'h0, m.first});
                chk({m.tag, ".ts"},     {28'h0, s_ts},     m.ts);
                chk({m.tag, ".vld"},    {31'h0, s_fv},     {31'h0, m.fv});
                chk({m.tag, ".irq"},    {31'h0, s_irq},    {31'h0, m.irq});
            end else begin
                chk({m.tag, ".sticky"}, {16'h0, l_sticky}, {16'h0, m.sticky});
                chk({m.tag, ".count"},  l_count,           m.count);
                chk({m.tag, ".first"},  {16'h0, l_first},  {16'h0, m.first});
                chk({m.tag, ".ts"},     l_ts,              m.ts);
                chk({m.tag, ".vld"},    {31'h0, l_fv},     {31'h0, m.fv});
                chk({m.tag, ".irq"},    {31'h0, l_irq},    {31'h0, m.irq});
            end
        end

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive(logic [15:0] v, logic vl, logic [15:0] cs, logic cc, logic cf);
        protocol_error = v; vld = vl; clr_sticky = cs; clr_count = cc; clr_first = cf;
    endtask

    task automatic goto(logic [31:0] t);
        while (ts_m < t) begin
            drive(16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        irq_en = 1'b1;
        repeat (3) tick();
        ap_rst_n = 1'b1;
        expect_nxt(0, "reset", 16'h0, 0, 16'h0, 0, 0, 0); tick();
        goto(100);
        drive(16'h0080, 1, 16'h0, 0, 0);
        expect_nxt(0, "single", 16'h0080, 1, 16'h0080, 100, 1, 1); tick();
        drive(16'h0, 0, 16'h0, 0, 0);
        expect_nxt(0, "single_hold", 16'h0080, 1, 16'h0080, 100, 1, 1); tick();
        drive(16'h0, 0, 16'h0080, 0, 0);
        expect_nxt(0, "clr_sticky", 16'h0, 1, 16'h0080, 100, 1, 0); tick();
        drive(16'h0, 0, 16'h0, 1, 1);
        expect_nxt(0, "clr_cnt_first", 16'h0, 0, 16'h0, 0, 0, 0); tick();
        drive(16'h0, 0, 16'h0, 0, 1);
        expect_nxt(0, "clr_first_idle", 16'h0, 0, 16'h0, 0, 0, 0); tick();
        goto(200);
        err_mask = 16'h0080;
        drive(16'h0081, 1, 16'h0, 0, 0);
        expect_nxt(0, "mask", 16'h0001, 1, 16'h0001, 200, 1, 1); tick();
        drive(16'h0004, 0, 16'h0, 0, 0);
        expect_nxt(0, "novld", 16'h0001, 1, 16'h0001, 200, 1, 1); tick();
        err_mask = 16'h0001;
        drive(16'h0, 0, 16'h0, 0, 0);
        expect_nxt(0, "mask_after", 16'h0001, 1, 16'h0001, 200, 1, 0); tick();
        err_mask = 16'h0;
        goto(300);
        drive(16'h0001, 1, 16'h0001, 0, 0);
        expect_nxt(0, "set_wins", 16'h0001, 2, 16'h0001, 200, 1, 1); tick();
        goto(500);
        drive(16'h2000, 1, 16'h0, 0, 1);
        expect_nxt(0, "recapture", 16'h2001, 3, 16'h2000, 500, 1, 1); tick();
        drive(16'h0002, 1, 16'h0, 1, 0);
        expect_nxt(0, "clr_cnt_ev", 16'h2003, 1, 16'h2000, 500, 1, 1); tick();
        drive(16'h0, 0, 16'hFFFF, 1, 1);
        expect_nxt(0, "clr_all", 16'h0, 0, 16'h0, 0, 0, 0); tick();
        goto(600);
        drive(16'h0001, 1, 16'h0, 0, 0);
        expect_nxt(0, "hold_a", 16'h0001, 1, 16'h0001, 600, 1, 1); tick();
        drive(16'h0010, 1, 16'h0, 0, 0);
        expect_nxt(0, "hold_b", 16'h0011, 2, 16'h0001, 600, 1, 1); tick();
        drive(16'h0, 0, 16'h0, 0, 1);
        expect_nxt(0, "release", 16'h0011, 2, 16'h0, 0, 0, 1); tick();
        irq_en = 1'b0;
        drive(16'h0, 0, 16'h0, 0, 0);
        expect_nxt(0, "irq_off", 16'h0011, 2, 16'h0, 0, 0, 0); tick();
        irq_en = 1'b1;
        drive(16'h0, 0, 16'hFFFF, 1, 0);
        expect_nxt(0, "pre_rst", 16'h0, 0, 16'h0, 0, 0, 0); tick();
        goto(700);
        drive(16'h0001, 1, 16'h0, 0, 0);
        expect_nxt(0, "burst1", 16'h0001, 1, 16'h0001, 700, 1, 1); tick();
        drive(16'h0040, 1, 16'h0, 0, 0);
        expect_nxt(0, "burst2", 16'h0041, 2, 16'h0001, 700, 1, 1); tick();
        drive(16'h0041, 1, 16'h0, 0, 0);
        expect_nxt(0, "burst3", 16'h0041, 3, 16'h0001, 700, 1, 1); tick();
        drive(16'h0001, 1, 16'h0, 0, 0);
        expect_nxt(0, "burst4", 16'h0041, 4, 16'h0001, 700, 1, 1); tick();
        drive(16'h0040, 1, 16'h0, 0, 0);
        expect_nxt(0, "burst5", 16'h0041, 5, 16'h0001, 700, 1, 1); tick();
        drive(16'h0, 0, 16'h0, 0, 0);
        expect_nxt(0, "burst_hold", 16'h0041, 5, 16'h0001, 700, 1, 1); tick();
        @(negedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("async_rst.sticky", {16'h0, l_sticky}, 32'h0);
        chk("async_rst.count", l_count, 32'h0);
        chk("async_rst.first", {16'h0, l_first}, 32'h0);
        chk("async_rst.ts", l_ts, 32'h0);
        chk("async_rst.vld", {31'h0, l_fv}, 32'h0);
        chk("async_rst.irq", {31'h0, l_irq}, 32'h0);
        tick();
        ap_rst_n = 1'b1;
        goto(32);
        for (int i = 0; i < 20; i++) begin
            drive(16'h0001, 1, 16'h0, 0, 0);
            expect_nxt(1, "sat_wrap", 16'h0001, (i + 1 > 15) ? 15 : i + 1, 16'h0001, 0, 1, 1);
            tick();
        end
        drive(16'h0, 0, 16'h0, 0, 0);
        expect_nxt(1, "sat_hold", 16'h0001, 15, 16'h0001, 0, 1, 1); tick();
        repeat (2) tick();
        chk("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
